// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock with a start/busy/done handshake.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend's low bits as remainder.
module restoring_divider #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state, state_next;

   logic [DW-1:0] q_reg;
   logic [VW-1:0] r_reg;
   logic [VW-1:0] d_reg;
   logic [CW-1:0] step_cnt;

   logic [VW:0]   trial;
   logic [VW:0]   diff;
   logic          fits;
   logic [DW-1:0] q_next;
   logic [VW-1:0] r_next;

   // The partial remainder always stays below the divisor, so the top bit of the
   // VW+1-bit difference is exactly the borrow: clear means trial >= divisor.
   always_comb begin
      trial  = {r_reg, q_reg[DW-1]};
      diff   = trial - {1'b0, d_reg};
      fits   = ~diff[VW];
      q_next = {q_reg[DW-2:0], fits};
      r_next = fits ? diff[VW-1:0] : trial[VW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (divisor != '0) ? CALC : DONE;
            end
         end
         CALC: begin
            if (step_cnt == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result registers are written only on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg       <= '0;
         r_reg       <= '0;
         d_reg       <= '0;
         step_cnt    <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     q_reg    <= dividend;
                     d_reg    <= divisor;
                     r_reg    <= '0;
                     step_cnt <= CW'(DW);
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend[VW-1:0];
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               q_reg    <= q_next;
               r_reg    <= r_next;
               step_cnt <= step_cnt - CW'(1);
               if (step_cnt == CW'(1)) begin
                  quotient    <= q_next;
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table, corner sequences,
// and randomized back-to-back divisions checked against plain integer division.
module tb_restoring_divider;

   localparam int DW = 8;
   localparam int VW = 4;
   localparam int NRAND = 1000;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   int pass_count = 0;
   int check_count = 0;

   restoring_divider #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          z;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
      check_count++;
      if (actual == expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Presents one request for a single accepting edge, then scrambles the operands.
   task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
   endtask

   task automatic runDivision(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                              input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez,
                              input bit interfere);
      logic [DW-1:0] q0;
      logic [VW-1:0] r0;
      logic          z0;
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at = -1;
      bit overlap = 0;
      bit early = 0;
      q0 = quotient;
      r0 = remainder;
      z0 = div_by_zero;
      applyStimulus(a, b);
      for (int i = 0; i <= DW + 2; i++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (busy && done) overlap = 1;
         if (done_at < 0 && (quotient !== q0 || remainder !== r0 || div_by_zero !== z0)) early = 1;
         if (interfere && i == 2) begin
            start    = 1'b1;
            dividend = 8'd50;
            divisor  = 4'd5;
         end
         if (interfere && i == 4) begin
            start    = 1'b0;
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
         end
         tick();
      end
      checkOutput({tag, " busy cycles"}, busy_cnt, (b == 0) ? 0 : DW);
      checkOutput({tag, " done count"}, done_cnt, 1);
      checkOutput({tag, " done index"}, 32'(done_at), (b == 0) ? 0 : DW);
      checkOutput({tag, " busy&done overlap"}, 32'(overlap), 0);
      checkOutput({tag, " outputs early"}, 32'(early), 0);
      checkOutput({tag, " quotient"}, 32'(quotient), 32'(eq));
      checkOutput({tag, " remainder"}, 32'(remainder), 32'(er));
      checkOutput({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " busy"}, 32'(busy), 0);
      checkOutput({tag, " done"}, 32'(done), 0);
      checkOutput({tag, " quotient"}, 32'(quotient), 0);
      checkOutput({tag, " remainder"}, 32'(remainder), 0);
      checkOutput({tag, " div_by_zero"}, 32'(div_by_zero), 0);
   endtask

   initial begin
      logic [DW-1:0] qa[$];
      logic [VW-1:0] qb[$];
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;
      int unsigned cyc;
      int unsigned last_done;
      int unsigned got;
      int late_done;

      vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
      vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
      vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
      vecs[3] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0};
      vecs[4] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
      vecs[5] = '{8'hA5,  4'd0,  8'hFF,  4'h5, 1'b1};
      vecs[6] = '{8'd9,   4'd2,  8'd4,   4'd1, 1'b0};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      checkAllZero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         runDivision($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, vecs[v].z, 1'b0);
      end

      runDivision("ignored start", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 1'b1);

      // Abort a division with an asynchronous reset in its fourth busy cycle.
      applyStimulus(8'd200, 4'd7);
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid-calc reset");
      tick();
      tick();
      rst_n = 1'b1;
      late_done = 0;
      for (int i = 0; i < DW + 4; i++) begin
         if (done) late_done++;
         tick();
      end
      checkOutput("no done after abort", late_done, 0);
      runDivision("after reset", 8'd13, 4'd4, 8'd3, 4'd1, 1'b0, 1'b0);

      // Back-to-back random divisions with start held high.
      cyc = 0;
      last_done = 0;
      got = 0;
      ra = DW'($urandom_range(255, 0));
      rb = VW'($urandom_range(15, 1));
      qa.push_back(ra);
      qb.push_back(rb);
      dividend = ra;
      divisor  = rb;
      start    = 1'b1;
      while (got < NRAND && cyc < NRAND * (DW + 2) + 50) begin
         tick();
         cyc++;
         if (done) begin
            ra = qa.pop_front();
            rb = qb.pop_front();
            checkOutput("rand quotient", 32'(quotient), 32'(ra) / 32'(rb));
            checkOutput("rand remainder", 32'(remainder), 32'(ra) % 32'(rb));
            checkOutput("rand div_by_zero", 32'(div_by_zero), 0);
            if (got > 0) checkOutput("rand done spacing", cyc - last_done, DW + 2);
            last_done = cyc;
            got++;
            if (got < NRAND) begin
               ra = DW'($urandom_range(255, 0));
               rb = VW'($urandom_range(15, 1));
               qa.push_back(ra);
               qb.push_back(rb);
               dividend = ra;
               divisor  = rb;
            end else begin
               start = 1'b0;
            end
         end
      end
      checkOutput("rand results collected", got, NRAND);

      tick();
      tick();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
